// File: rtl/axi_read_slave_if.sv
`default_nettype none
//============================================================================
// axi_read_slave_if : AXI read-channel (AR + R) signal bundle
// Rev 1.0
//============================================================================
interface axi_read_slave_if #(
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic                  ARVALID;
  logic                  ARREADY;
  logic [ID_WIDTH-1:0]   ARID;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [3:0]            ARLEN;
  logic [1:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic                  RVALID;
  logic                  RREADY;
  logic [ID_WIDTH-1:0]   RID;
  logic [BUS_WIDTH-1:0]  RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;

  modport master (
    output ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST, RREADY,
    input  ARREADY, RVALID, RID, RDATA, RRESP, RLAST
  );

  modport slave (
    input  ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST, RREADY,
    output ARREADY, RVALID, RID, RDATA, RRESP, RLAST
  );
endinterface
`default_nettype wire

// File: rtl/axi_read_slave.sv
`default_nettype none
//============================================================================
// axi_read_slave : one-burst-at-a-time AXI read responder over a sync memory
// Rev 1.0
//============================================================================
module axi_read_slave #(
  parameter int BUS_WIDTH      = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int MEM_ADDR_WIDTH = 7
) (
  input  wire logic                      clk,
  input  wire logic                      clr,
  axi_read_slave_if.slave                axi,
  output logic                           mem_read,
  output logic [MEM_ADDR_WIDTH-1:0]      mem_raddr,
  input  wire logic [BUS_WIDTH-1:0]      mem_rdata
);
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t                    state_q, state_d;
  logic                      arready_q, arready_d;
  logic                      rvalid_q, rvalid_d;
  logic                      rlast_q, rlast_d;
  logic [BUS_WIDTH-1:0]      rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;
  logic [ID_WIDTH-1:0]       id_q, id_d;
  logic                      mem_read_q, mem_read_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_raddr_q, mem_raddr_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [3:0]                len_q, len_d;
  logic [3:0]                count_q, count_d;
  logic [1:0]                size_q, size_d;
  logic [1:0]                burst_q, burst_d;
  logic [1:0]                err_q, err_d;

  logic [ADDR_WIDTH-1:0]     inc;
  logic [ADDR_WIDTH-1:0]     wrap_mask;
  logic [ADDR_WIDTH-1:0]     next_addr;
  logic [1:0]                ar_err;

  // Malformed requests outrank out-of-range addresses.
  always_comb begin
    ar_err = RESP_OKAY;
    if (axi.ARBURST == 2'd3 || axi.ARSIZE == 2'd3 ||
        (axi.ARBURST == BURST_WRAP && !(axi.ARLEN inside {4'd1, 4'd3, 4'd7, 4'd15})))
      ar_err = RESP_SLVERR;
    else if (|axi.ARADDR[ADDR_WIDTH-1:MEM_ADDR_WIDTH])
      ar_err = RESP_DECERR;
  end

  always_comb begin
    inc       = ADDR_WIDTH'(1) << size_q;
    wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
    case (burst_q)
      BURST_INCR: next_addr = addr_q + inc;
      BURST_WRAP: next_addr = (addr_q & ~wrap_mask) | ((addr_q + inc) & wrap_mask);
      default:    next_addr = addr_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    arready_d   = arready_q;
    rvalid_d    = rvalid_q;
    rlast_d     = rlast_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    id_d        = id_q;
    mem_read_d  = mem_read_q;
    mem_raddr_d = mem_raddr_q;
    addr_d      = addr_q;
    len_d       = len_q;
    count_d     = count_q;
    size_d      = size_q;
    burst_d     = burst_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        arready_d = 1'b1;
        if (arready_q && axi.ARVALID) begin
          arready_d   = 1'b0;
          id_d        = axi.ARID;
          addr_d      = axi.ARADDR;
          len_d       = axi.ARLEN;
          count_d     = axi.ARLEN;
          size_d      = axi.ARSIZE;
          burst_d     = axi.ARBURST;
          err_d       = ar_err;
          // Outputs are registered, so the read strobe is set up on entry to ISSUE.
          mem_read_d  = (ar_err == RESP_OKAY);
          mem_raddr_d = axi.ARADDR[MEM_ADDR_WIDTH-1:0];
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        mem_read_d = 1'b0;
        state_d    = CAPTURE;
      end
      CAPTURE: begin
        rdata_d  = (err_q == RESP_OKAY) ? mem_rdata : '0;
        rvalid_d = 1'b1;
        rlast_d  = (count_q == 4'd0);
        rresp_d  = err_q;
        state_d  = RESP;
      end
      RESP: begin
        if (axi.RREADY) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          if (rlast_q) begin
            arready_d = 1'b1;
            state_d   = IDLE;
          end else begin
            count_d     = count_q - 4'd1;
            addr_d      = next_addr;
            mem_read_d  = (err_q == RESP_OKAY);
            mem_raddr_d = next_addr[MEM_ADDR_WIDTH-1:0];
            state_d     = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= RESP_OKAY;
      id_q        <= '0;
      mem_read_q  <= 1'b0;
      mem_raddr_q <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      count_q     <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      err_q       <= RESP_OKAY;
    end else begin
      state_q     <= state_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rlast_q     <= rlast_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      id_q        <= id_d;
      mem_read_q  <= mem_read_d;
      mem_raddr_q <= mem_raddr_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      count_q     <= count_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      err_q       <= err_d;
    end
  end

  assign axi.ARREADY = arready_q;
  assign axi.RVALID  = rvalid_q;
  assign axi.RLAST   = rlast_q;
  assign axi.RDATA   = rdata_q;
  assign axi.RRESP   = rresp_q;
  assign axi.RID     = id_q;
  assign mem_read    = mem_read_q;
  assign mem_raddr   = mem_raddr_q;
endmodule
`default_nettype wire
